// File: rtl/battle_pkg.sv
// Shared types and constants for the two-player battle sequencer.
package battle_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM1   = 3'd1,
        S_P1     = 3'd2,
        S_ARM2   = 3'd3,
        S_P2     = 3'd4,
        S_RESULT = 3'd5
    } state_e;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_TIE  = 2'b11;

    localparam int SCORE_W_DEF  = 8;
    localparam int NUM_KEYS_DEF = 8;

endpackage

// File: rtl/battle_controller_key_edge_detect.sv
// Registers the key vector and flags a cycle in which at least one key bit rose.
module key_edge_detect #(
    parameter int NUM_KEYS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic                any_rise_o
);

    logic [NUM_KEYS-1:0] key_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) key_q <= '0;
        else         key_q <= key_i;
    end

    assign any_rise_o = |(key_i & ~key_q);

endmodule

// File: rtl/battle_controller.sv
// Two-turn battle sequencer: arms the minute timer per player, counts press
// edges into saturating scores, then latches the winner.
module battle_controller
    import battle_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int SCORE_W  = SCORE_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                timer,
    output logic                battle,
    output logic                restart,
    output logic [1:0]          active_player,
    output logic [SCORE_W-1:0]  score_p1,
    output logic [SCORE_W-1:0]  score_p2,
    output logic [1:0]          winner,
    output logic                done
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         win_q, win_d;
    logic               press;

    key_edge_detect #(.NUM_KEYS(NUM_KEYS)) u_edge (
        .clk_i      (clk),
        .rst_ni     (reset),
        .key_i      (key),
        .any_rise_o (press)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= WINNER_NONE;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        // abort wins over everything and leaves the scoreboard untouched
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_RESULT: begin
                    if (start) begin
                        state_d = S_ARM1;
                        p1_d    = '0;
                        p2_d    = '0;
                        win_d   = WINNER_NONE;
                    end
                end
                S_ARM1: state_d = S_P1;
                S_P1: begin
                    if (press && p1_q != SCORE_MAX) p1_d = p1_q + 1'b1;
                    if (timer) state_d = S_ARM2;
                end
                S_ARM2: state_d = S_P2;
                S_P2: begin
                    if (press && p2_q != SCORE_MAX) p2_d = p2_q + 1'b1;
                    // winner must see a press landing on the final cycle
                    if (timer) begin
                        state_d = S_RESULT;
                        if (p1_q > p2_d)      win_d = WINNER_P1;
                        else if (p2_d > p1_q) win_d = WINNER_P2;
                        else                  win_d = WINNER_TIE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        battle        = 1'b0;
        restart       = 1'b0;
        active_player = 2'b00;
        done          = 1'b0;
        case (state_q)
            S_ARM1, S_ARM2: restart = 1'b1;
            S_P1: begin
                battle        = 1'b1;
                active_player = 2'b01;
            end
            S_P2: begin
                battle        = 1'b1;
                active_player = 2'b10;
            end
            S_RESULT: done = 1'b1;
            default: ;
        endcase
    end

    assign score_p1 = p1_q;
    assign score_p2 = p2_q;
    assign winner   = win_q;

endmodule

// File: tb/tb_battle_controller.sv
// Bench for battle_controller: timer model, planned key streams per turn,
// scoreboard of expected final scores checked when done rises.
module tb_battle_controller;

    localparam int PERIOD = 40;
    localparam int T      = PERIOD + 1;   // cycles a turn lasts with this timer

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] key = 8'h00;
    logic       timer;

    logic       battle_a, restart_a, done_a, battle_b, restart_b, done_b;
    logic [1:0] ap_a, win_a, ap_b, win_b;
    logic [7:0] sp1_a, sp2_a;
    logic [3:0] sp1_b, sp2_b;
    logic [4:0] ctl_a, ctl_b;

    always #5 clk = ~clk;

    battle_controller #(.NUM_KEYS(8), .SCORE_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .key(key), .timer(timer),
        .battle(battle_a), .restart(restart_a), .active_player(ap_a),
        .score_p1(sp1_a), .score_p2(sp2_a), .winner(win_a), .done(done_a));

    battle_controller #(.NUM_KEYS(8), .SCORE_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .key(key), .timer(timer),
        .battle(battle_b), .restart(restart_b), .active_player(ap_b),
        .score_p1(sp1_b), .score_p2(sp2_b), .winner(win_b), .done(done_b));

    assign ctl_a = {battle_a, restart_a, ap_a, done_a};
    assign ctl_b = {battle_b, restart_b, ap_b, done_b};

    // Behavioural minute timer: counts enabled cycles, flag sticks until restart
    int   tcnt;
    logic tflag;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt  <= 0;
            tflag <= 1'b0;
        end else if (restart_a) begin
            tcnt  <= 0;
            tflag <= 1'b0;
        end else if (battle_a && !tflag) begin
            if (tcnt == PERIOD - 1) tflag <= 1'b1;
            tcnt <= tcnt + 1;
        end
    end
    assign timer = tflag;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic int wexp(input int a, input int b);
        return (a > b) ? 1 : ((b > a) ? 2 : 3);
    endfunction

    typedef struct { int p1; int p2; } exp_t;
    exp_t sbq[$];

    localparam logic [4:0] C_IDLE = 5'b00000, C_ARM = 5'b01000, C_P1 = 5'b10010,
                           C_P2 = 5'b10100, C_RES = 5'b00001;

    logic [7:0] p1k [T];
    logic [7:0] p2k [T];
    logic [7:0] arm2k;
    logic [7:0] kprev = 8'h00;

    // A press is any bit going 0->1 relative to the previous cycle's keys
    task automatic drive_key(input logic [7:0] k, output bit rose);
        rose  = |(k & ~kprev);
        kprev = k;
        key   = k;
    endtask

    task automatic fill_pulses(input int n1, input int n2);
        for (int i = 0; i < T; i++) begin
            p1k[i] = (i % 2 == 0 && i / 2 < n1) ? 8'(1 << ((i / 2) % 8)) : 8'h00;
            p2k[i] = (i % 2 == 0 && i / 2 < n2) ? 8'(1 << ((i / 2) % 8)) : 8'h00;
        end
        arm2k = 8'h00;
    endtask

    task automatic fill_random();
        for (int i = 0; i < T; i++) begin
            p1k[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ((i > 0) ? p1k[i-1] : 8'h00);
            p2k[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ((i > 0) ? p2k[i-1] : 8'h00);
        end
        arm2k = 8'($urandom);
    endtask

    task automatic check_scores(input string tag, input int c1, input int c2);
        check({tag, ".p1_w8"}, int'(sp1_a), sat(c1, 255));
        check({tag, ".p2_w8"}, int'(sp2_a), sat(c2, 255));
        check({tag, ".p1_w4"}, int'(sp1_b), sat(c1, 15));
        check({tag, ".p2_w4"}, int'(sp2_b), sat(c2, 15));
    endtask

    // One game from IDLE/RESULT; optional reset inside P1 or abort inside P2
    task automatic play(input string tag, input int rst_idx, input int abort_idx);
        int c1, c2;
        bit r;
        c1 = 0;
        c2 = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, ".arm1_ctl"}, int'(ctl_a), int'(C_ARM));
        check({tag, ".arm1_ctl_b"}, int'(ctl_b), int'(C_ARM));
        check_scores({tag, ".arm1_clr"}, 0, 0);
        check({tag, ".arm1_win"}, int'(win_a), 0);
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            check({tag, ".p1_ctl"}, int'(ctl_a), int'(C_P1));
            if (i == rst_idx) begin
                check_scores({tag, ".pre_rst"}, c1, 0);
                #2 reset = 1'b0;
                #1;
                check({tag, ".rst_ctl"}, int'(ctl_a), 0);
                check({tag, ".rst_ctl_b"}, int'(ctl_b), 0);
                check_scores({tag, ".rst"}, 0, 0);
                check({tag, ".rst_win"}, int'(win_a), 0);
                @(negedge clk);
                key   = 8'h00;
                kprev = 8'h00;
                reset = 1'b1;
                return;
            end
            drive_key(p1k[i], r);
            if (r) c1++;
        end
        @(negedge clk);
        check({tag, ".arm2_ctl"}, int'(ctl_a), int'(C_ARM));
        drive_key(arm2k, r);
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            check({tag, ".p2_ctl"}, int'(ctl_a), int'(C_P2));
            check({tag, ".p2_ctl_b"}, int'(ctl_b), int'(C_P2));
            if (i == abort_idx) begin
                abort = 1'b1;
                start = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check({tag, ".abort_ctl"}, int'(ctl_a), int'(C_IDLE));
                check_scores({tag, ".abort_hold"}, c1, c2);
                check({tag, ".abort_win"}, int'(win_a), 0);
                return;
            end
            drive_key(p2k[i], r);
            if (r) c2++;
        end
        sbq.push_back('{p1: c1, p2: c2});
        @(negedge clk);
        check({tag, ".res_ctl"}, int'(ctl_a), int'(C_RES));
        @(negedge clk);
        check({tag, ".res_hold"}, int'(ctl_a), int'(C_RES));
    endtask

    // Scoreboard monitor: result is compared when done rises
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done_a && !done_prev) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_done", 1, 0);
            end else begin
                check("sb_p1_w8", int'(sp1_a), sat(sbq[0].p1, 255));
                check("sb_p2_w8", int'(sp2_a), sat(sbq[0].p2, 255));
                check("sb_win_w8", int'(win_a), wexp(sat(sbq[0].p1, 255), sat(sbq[0].p2, 255)));
                check("sb_p1_w4", int'(sp1_b), sat(sbq[0].p1, 15));
                check("sb_p2_w4", int'(sp2_b), sat(sbq[0].p2, 15));
                check("sb_win_w4", int'(win_b), wexp(sat(sbq[0].p1, 15), sat(sbq[0].p2, 15)));
                sbq.delete(0);
            end
        end
        done_prev <= done_a;
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ctl", int'(ctl_a), 0);
        check("reset_ctl_b", int'(ctl_b), 0);
        check_scores("reset", 0, 0);
        check("reset_win", int'(win_a), 0);
        reset = 1'b1;

        fill_pulses(10, 0);  play("rst_mid_p1", 10, -1);
        fill_pulses(7, 3);   play("p7_p3", -1, -1);
        fill_pulses(4, 4);   play("tie", -1, -1);

        fill_pulses(0, 0);
        for (int i = 3; i < T; i++) p1k[i] = 8'hFF;
        arm2k = 8'hFF;
        for (int i = 0; i < 5; i++) p2k[i] = 8'hFF;
        play("all_keys_held", -1, -1);

        fill_pulses(20, 3);  play("saturate", -1, -1);
        fill_pulses(5, 5);   play("abort_p2", -1, 10);

        fill_pulses(2, 2);
        p2k[T-1] = 8'h10;
        play("last_cycle_press", -1, -1);

        repeat (6) begin
            fill_random();
            play("random", -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T - 1)) : -1);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
